// File: rtl/obi_bus_arbiter.sv
// Merges an instruction and a data OBI manager onto one shared OBI manager port.
// Round-robin address arbitration with in-order response routing via a small route FIFO.
module obi_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned INSTR_WIDTH    = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,

   input  logic                    imem_req_i,
   output logic                    imem_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
   output logic                    imem_rvalid_o,
   output logic [INSTR_WIDTH-1:0]  imem_rdata_o,
   output logic                    imem_err_o,

   input  logic                    dmem_req_i,
   output logic                    dmem_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
   input  logic                    dmem_we_i,
   input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] dmem_be_i,
   output logic                    dmem_rvalid_o,
   output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
   output logic                    dmem_err_o,

   output logic                    mem_req_o,
   input  logic                    mem_gnt_i,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_err_i,

   output logic                    proto_err_o
);

   localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
      $fatal(1, "obi_bus_arbiter: DATA_WIDTH must be 32 or 64");
   end
   if (MaxOutstanding < 1) begin : g_bad_depth
      $fatal(1, "obi_bus_arbiter: MaxOutstanding must be >= 1");
   end

   typedef enum logic [1:0] {StIdle, StLockI, StLockD} state_e;

   state_e                state_q, state_d;
   logic                  prefer_d_q;
   logic                  proto_err_q;
   logic                  fifo_port_q [MaxOutstanding];
   logic                  fifo_a2_q   [MaxOutstanding];
   logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntWidth-1:0]   count_q;

   logic                  sel_d, sel_req;
   logic                  fifo_full, fifo_empty;
   logic                  handshake, resp_valid;
   logic                  head_port, head_a2;
   logic [63:0]           rdata_ext;
   logic [31:0]           instr_word;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
   endfunction

   // A locked selection is held until its grant so the address phase stays stable.
   always_comb begin
      sel_d   = 1'b0;
      sel_req = 1'b0;
      unique case (state_q)
         StLockI: begin
            sel_d   = 1'b0;
            sel_req = imem_req_i;
         end
         StLockD: begin
            sel_d   = 1'b1;
            sel_req = dmem_req_i;
         end
         default: begin
            sel_d   = (imem_req_i && dmem_req_i) ? prefer_d_q : dmem_req_i;
            sel_req = imem_req_i | dmem_req_i;
         end
      endcase
   end

   assign fifo_full  = (count_q == CntWidth'(MaxOutstanding));
   assign fifo_empty = (count_q == '0);

   // Full blocks the request even if a response pops this cycle: no rvalid-to-req path.
   assign mem_req_o   = sel_req & ~fifo_full & ~rst_i;
   assign handshake   = mem_req_o & mem_gnt_i;
   assign imem_gnt_o  = handshake & ~sel_d;
   assign dmem_gnt_o  = handshake & sel_d;
   assign mem_addr_o  = sel_d ? dmem_addr_i : imem_addr_i;
   assign mem_we_o    = sel_d & dmem_we_i;
   assign mem_wdata_o = sel_d ? dmem_wdata_i : '0;
   assign mem_be_o    = sel_d ? dmem_be_i : '1;

   always_comb begin
      state_d = StIdle;
      if (!handshake && sel_req) begin
         state_d = sel_d ? StLockD : StLockI;
      end
   end

   assign head_port  = fifo_port_q[rd_ptr_q];
   assign head_a2    = fifo_a2_q[rd_ptr_q];
   assign resp_valid = mem_rvalid_i & ~fifo_empty & ~rst_i;

   assign rdata_ext  = 64'(mem_rdata_i);
   assign instr_word = (head_a2 && DATA_WIDTH == 64) ? rdata_ext[63:32] : rdata_ext[31:0];

   assign imem_rvalid_o = resp_valid & ~head_port;
   assign dmem_rvalid_o = resp_valid & head_port;
   assign imem_err_o    = imem_rvalid_o & mem_err_i;
   assign dmem_err_o    = dmem_rvalid_o & mem_err_i;
   assign imem_rdata_o  = imem_rvalid_o ? INSTR_WIDTH'(instr_word) : '0;
   assign dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : '0;
   assign proto_err_o   = proto_err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         prefer_d_q  <= 1'b1;
         proto_err_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q <= state_d;
         if (handshake) begin
            fifo_port_q[wr_ptr_q] <= sel_d;
            fifo_a2_q[wr_ptr_q]   <= mem_addr_o[2];
            wr_ptr_q              <= ptr_inc(wr_ptr_q);
            prefer_d_q            <= ~sel_d;
         end
         if (resp_valid) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (handshake && !resp_valid) begin
            count_q <= count_q + 1'b1;
         end else if (!handshake && resp_valid) begin
            count_q <= count_q - 1'b1;
         end
         if (mem_rvalid_i && fifo_empty) begin
            proto_err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_obi_bus_arbiter.sv
// Vector-table bench for obi_bus_arbiter: a 32-bit and a 64-bit instance share one stimulus
// stream; response routing is checked against a queue of expected outstanding transfers.
module tb_obi_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ireq, dreq, dwe, gnt, rv, err;
   logic [31:0] iaddr, daddr;
   logic [63:0] dwd, rdata;

   logic        i_gnt32, i_rv32, i_err32, d_gnt32, d_rv32, d_err32, m_req32, m_we32, perr32;
   logic [31:0] i_rd32, d_rd32, m_addr32, m_wd32;
   logic [3:0]  m_be32;

   logic        i_gnt64, i_rv64, i_err64, d_gnt64, d_rv64, d_err64, m_req64, m_we64, perr64;
   logic [31:0] i_rd64, m_addr64;
   logic [63:0] d_rd64, m_wd64;
   logic [7:0]  m_be64;

   assign dwd = {~daddr, daddr};

   obi_bus_arbiter #(.DATA_WIDTH(32)) dut32 (
      .clk_i(clk), .rst_i(rst),
      .imem_req_i(ireq), .imem_gnt_o(i_gnt32), .imem_addr_i(iaddr),
      .imem_rvalid_o(i_rv32), .imem_rdata_o(i_rd32), .imem_err_o(i_err32),
      .dmem_req_i(dreq), .dmem_gnt_o(d_gnt32), .dmem_addr_i(daddr), .dmem_we_i(dwe),
      .dmem_wdata_i(dwd[31:0]), .dmem_be_i(4'h3),
      .dmem_rvalid_o(d_rv32), .dmem_rdata_o(d_rd32), .dmem_err_o(d_err32),
      .mem_req_o(m_req32), .mem_gnt_i(gnt), .mem_addr_o(m_addr32), .mem_we_o(m_we32),
      .mem_wdata_o(m_wd32), .mem_be_o(m_be32), .mem_rvalid_i(rv),
      .mem_rdata_i(rdata[31:0]), .mem_err_i(err), .proto_err_o(perr32)
   );

   obi_bus_arbiter #(.DATA_WIDTH(64)) dut64 (
      .clk_i(clk), .rst_i(rst),
      .imem_req_i(ireq), .imem_gnt_o(i_gnt64), .imem_addr_i(iaddr),
      .imem_rvalid_o(i_rv64), .imem_rdata_o(i_rd64), .imem_err_o(i_err64),
      .dmem_req_i(dreq), .dmem_gnt_o(d_gnt64), .dmem_addr_i(daddr), .dmem_we_i(dwe),
      .dmem_wdata_i(dwd), .dmem_be_i(8'h33),
      .dmem_rvalid_o(d_rv64), .dmem_rdata_o(d_rd64), .dmem_err_o(d_err64),
      .mem_req_o(m_req64), .mem_gnt_i(gnt), .mem_addr_o(m_addr64), .mem_we_o(m_we64),
      .mem_wdata_o(m_wd64), .mem_be_o(m_be64), .mem_rvalid_i(rv),
      .mem_rdata_i(rdata), .mem_err_i(err), .proto_err_o(perr64)
   );

   typedef struct {
      logic        rst, ireq, dreq, dwe, gnt, rv, err;
      logic [31:0] iaddr, daddr;
      logic [63:0] rdata;
      logic        exp_req, exp_ig, exp_dg, exp_seld, exp_perr;
      logic [31:0] exp_addr;
   } vec_t;

   typedef struct {
      logic port;  // 1 = data
      logic a2;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   checks = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic [31:0] da, input logic w,
                               input logic g, input logic v, input logic [63:0] rd,
                               input logic e, input logic x_req, input logic x_ig,
                               input logic x_dg, input logic x_seld, input logic [31:0] x_addr,
                               input logic x_perr);
      vec_t t;
      t.rst = r;  t.ireq = ir; t.iaddr = ia; t.dreq = dr; t.daddr = da; t.dwe = w;
      t.gnt = g;  t.rv = v;    t.rdata = rd; t.err = e;
      t.exp_req = x_req; t.exp_ig = x_ig; t.exp_dg = x_dg; t.exp_seld = x_seld;
      t.exp_addr = x_addr; t.exp_perr = x_perr;
      return t;
   endfunction

   task automatic chk(input string nm, input int cyc, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int cyc);
      sb_t         e;
      logic        x_irv, x_drv, x_ierr, x_derr;
      logic [31:0] x_ird32, x_ird64, x_drd32;
      logic [63:0] x_drd64;
      rst = v.rst; ireq = v.ireq; iaddr = v.iaddr; dreq = v.dreq; daddr = v.daddr;
      dwe = v.dwe; gnt = v.gnt; rv = v.rv; rdata = v.rdata; err = v.err;
      x_irv = 1'b0; x_drv = 1'b0; x_ierr = 1'b0; x_derr = 1'b0;
      x_ird32 = '0; x_ird64 = '0; x_drd32 = '0; x_drd64 = '0;
      if (v.rv && !v.rst && sb.size() > 0) begin
         e = sb.pop_front();
         if (e.port) begin
            x_drv = 1'b1; x_derr = v.err; x_drd32 = v.rdata[31:0]; x_drd64 = v.rdata;
         end else begin
            x_irv = 1'b1; x_ierr = v.err; x_ird32 = v.rdata[31:0];
            x_ird64 = e.a2 ? v.rdata[63:32] : v.rdata[31:0];
         end
      end
      @(negedge clk);
      chk("mem_req", cyc, 64'(m_req32), 64'(v.exp_req));
      chk("imem_gnt", cyc, 64'(i_gnt32), 64'(v.exp_ig));
      chk("dmem_gnt", cyc, 64'(d_gnt32), 64'(v.exp_dg));
      chk("proto_err", cyc, 64'(perr32), 64'(v.exp_perr));
      chk("imem_rvalid", cyc, 64'(i_rv32), 64'(x_irv));
      chk("dmem_rvalid", cyc, 64'(d_rv32), 64'(x_drv));
      chk("imem_rdata", cyc, 64'(i_rd32), 64'(x_ird32));
      chk("dmem_rdata", cyc, 64'(d_rd32), 64'(x_drd32));
      chk("imem_err", cyc, 64'(i_err32), 64'(x_ierr));
      chk("dmem_err", cyc, 64'(d_err32), 64'(x_derr));
      chk("mem_req64", cyc, 64'(m_req64), 64'(v.exp_req));
      chk("imem_rdata64", cyc, 64'(i_rd64), 64'(x_ird64));
      chk("dmem_rdata64", cyc, d_rd64, x_drd64);
      if (v.exp_req) begin
         chk("mem_addr", cyc, 64'(m_addr32), 64'(v.exp_addr));
         chk("mem_we", cyc, 64'(m_we32), 64'(v.exp_seld & v.dwe));
         chk("mem_be", cyc, 64'(m_be32), v.exp_seld ? 64'h3 : 64'hF);
         chk("mem_wdata", cyc, 64'(m_wd32), v.exp_seld ? 64'(v.daddr) : 64'h0);
         chk("mem_be64", cyc, 64'(m_be64), v.exp_seld ? 64'h33 : 64'hFF);
      end
      if (v.exp_ig) sb.push_back('{port: 1'b0, a2: v.iaddr[2]});
      if (v.exp_dg) sb.push_back('{port: 1'b1, a2: v.daddr[2]});
      @(posedge clk);
      #1;
      if (v.rst) sb.delete();
   endtask

   initial begin
      rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; gnt = 1'b0; rv = 1'b0; err = 1'b0;
      iaddr = '0; daddr = '0; rdata = '0;
      @(posedge clk);
      #1;
      //            rst ireq iaddr  dreq daddr   we gnt rv rdata                 err
      //            req ig dg seld addr perr
      vecs.push_back(mk(1, 1, 'h100, 1, 'h1000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // single fetch, then its response
      vecs.push_back(mk(0, 1, 'h100, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 'h100, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
      // simultaneous requests: data first, then instruction; FIFO fills
      vecs.push_back(mk(0, 1, 'h200, 1, 'h1000, 1, 1, 0, 0, 0, 1, 0, 1, 1, 'h1000, 0));
      vecs.push_back(mk(0, 1, 'h200, 1, 'h1004, 1, 1, 0, 0, 0, 1, 1, 0, 0, 'h200, 0));
      vecs.push_back(mk(0, 0, 0, 1, 'h1004, 1, 1, 1, 'hAAAA5555_CAFE0001, 0,
                        0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 'h1004, 1, 1, 1, 'h12345678_9ABCDEF0, 1,
                        1, 0, 1, 1, 'h1004, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h0BADF00D_00001234, 0, 0, 0, 0, 0, 0, 0));
      // lock: data held three ungranted cycles, then instruction wins round-robin
      vecs.push_back(mk(0, 1, 'h300, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 'h300, 0));
      vecs.push_back(mk(0, 1, 'h304, 1, 'h2000, 0, 0, 1, 'hFFFF0000_00C0FFEE, 0,
                        1, 0, 0, 1, 'h2000, 0));
      vecs.push_back(mk(0, 1, 'h304, 1, 'h2000, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h2000, 0));
      vecs.push_back(mk(0, 1, 'h304, 1, 'h2000, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h2000, 0));
      vecs.push_back(mk(0, 1, 'h304, 1, 'h2000, 0, 1, 0, 0, 0, 1, 0, 1, 1, 'h2000, 0));
      vecs.push_back(mk(0, 1, 'h304, 1, 'h2008, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h304, 0));
      vecs.push_back(mk(0, 1, 'h304, 1, 'h2008, 0, 1, 0, 0, 0, 1, 1, 0, 0, 'h304, 0));
      // full FIFO: pop in same cycle still blocks; next cycle request goes out
      vecs.push_back(mk(0, 0, 0, 1, 'h2008, 0, 1, 1, 'h55555555_66666666, 0,
                        0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 'h2008, 0, 1, 1, 'h11112222_33334444, 0,
                        1, 0, 1, 1, 'h2008, 0));
      vecs.push_back(mk(0, 1, 'h100, 0, 0, 0, 1, 1, 'h77778888_9999AAAA, 1,
                        1, 1, 0, 0, 'h100, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h11112222_33334444, 0, 0, 0, 0, 0, 0, 0));
      // unexpected response
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hBBBBCCCC_DDDDEEEE, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // reset mid-lock with one outstanding
      vecs.push_back(mk(0, 0, 0, 1, 'h3000, 1, 1, 0, 0, 0, 1, 0, 1, 1, 'h3000, 1));
      vecs.push_back(mk(0, 1, 'h404, 1, 'h3004, 1, 0, 0, 0, 0, 1, 0, 0, 0, 'h404, 1));
      vecs.push_back(mk(1, 1, 'h404, 1, 'h3004, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 'h404, 1, 'h3004, 1, 0, 0, 0, 0, 1, 0, 0, 1, 'h3004, 0));
      vecs.push_back(mk(0, 1, 'h404, 1, 'h3004, 1, 0, 1, 'h1, 0, 1, 0, 0, 1, 'h3004, 0));
      vecs.push_back(mk(0, 1, 'h404, 1, 'h3004, 1, 1, 0, 0, 0, 1, 0, 1, 1, 'h3004, 1));
      vecs.push_back(mk(0, 1, 'h404, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 'h404, 1));
      vecs.push_back(mk(0, 0, 0, 1, 'h3008, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 'h3008, 0, 1, 1, 'hA, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 'h3008, 0, 1, 1, 'hCCCCCCCC_DDDDDDDD, 0,
                        1, 0, 1, 1, 'h3008, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hE, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i], i);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/obi_bus_arbiter.md
Name: obi_bus_arbiter

Overview:
- Sits directly downstream of the core: merges the core's instruction OBI manager port (imem_*) and data OBI manager port (dmem_*) onto one shared OBI manager port toward a unified memory or interconnect.
- Arbitrates address phases round-robin and holds the selection stable until the grant.
- Routes in-order responses back to the originating port through a small outstanding-transaction FIFO.
- For DATA_WIDTH=64, extracts the 32-bit instruction word selected by address bit 2.

Parameters:
ADDR_WIDTH, 32, address width of all ports.
DATA_WIDTH, 32, data width of the data and shared ports; 32 or 64 only, any other value is a fatal elaboration error.
INSTR_WIDTH, 32, instruction port read data width.
MaxOutstanding, 2, route FIFO depth, i.e. the maximum number of granted-but-unanswered transactions; must be >=1.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  reset; synchronous, active-high.
imem_req_i  in  1  instruction address request.
imem_gnt_o  out  1  instruction grant.
imem_addr_i  in  ADDR_WIDTH  instruction address.
imem_rvalid_o  out  1  instruction response valid.
imem_rdata_o  out  INSTR_WIDTH  instruction read data.
imem_err_o  out  1  instruction error response.
dmem_req_i  in  1  data address request.
dmem_gnt_o  out  1  data grant.
dmem_addr_i  in  ADDR_WIDTH  data address.
dmem_we_i  in  1  data write enable.
dmem_wdata_i  in  DATA_WIDTH  data write data.
dmem_be_i  in  DATA_WIDTH/8  data byte enables.
dmem_rvalid_o  out  1  data response valid.
dmem_rdata_o  out  DATA_WIDTH  data read data.
dmem_err_o  out  1  data error response.
mem_req_o  out  1  shared request.
mem_gnt_i  in  1  shared grant.
mem_addr_o  out  ADDR_WIDTH  shared address.
mem_we_o  out  1  shared write enable.
mem_wdata_o  out  DATA_WIDTH  shared write data.
mem_be_o  out  DATA_WIDTH/8  shared byte enables.
mem_rvalid_i  in  1  shared response valid.
mem_rdata_i  in  DATA_WIDTH  shared read data.
mem_err_i  in  1  shared error response.
proto_err_o  out  1  sticky flag: response received with no outstanding transaction.

Behaviour:
- Reset (rst_i=1 at a clk_i edge), including mid-transaction:
  - FIFO emptied, lock cleared, round-robin pointer set to prefer data, proto_err_o=0.
  - All outputs are combinational from cleared state, so while rst_i is held: mem_req_o=0, all gnt/rvalid/err outputs 0.
  - Responses to pre-reset transactions arriving after reset count as unexpected (see below).
- Selection state: IDLE, LOCK_I, LOCK_D.
  - In IDLE with both ports requesting, the port not granted last wins. In IDLE with one port requesting, that port wins.
  - The winner drives mem_* combinationally in the same cycle (zero-cycle address path).
  - If the winner's mem_req_o is not granted that cycle, the state moves to LOCK_I or LOCK_D. Selection stays fixed until mem_gnt_i, then returns to IDLE. This keeps the OBI address phase stable.
  - The losing port sees gnt=0 and must hold its request.
- Instruction transfers drive mem_we_o=0, mem_be_o all ones, mem_wdata_o=0.
- mem_req_o = selected req AND NOT fifo_full. If full, no request is issued, even if a response pops in the same cycle. This avoids an rvalid-to-req combinational path.
- Grant to the selected port = mem_gnt_i AND mem_req_o.
- A handshake (mem_req_o AND mem_gnt_i) pushes {port_id, addr[2]} into the FIFO and updates last-granted.
- Responses are in order:
  - mem_rvalid_i with FIFO non-empty routes rvalid, rdata and err to the head entry's port, then pops.
  - The other port's rvalid=0.
  - Push and pop in the same cycle leave the count unchanged.
- Instruction rdata:
  - DATA_WIDTH=32: mem_rdata_i passes through.
  - DATA_WIDTH=64: upper half if the stored addr bit 2 is 1, else lower half.
- Data rdata passes through unmodified. rdata outputs on non-routed ports are 0.
- Unexpected response (mem_rvalid_i with FIFO empty): dropped, no rvalid to either port, proto_err_o set to 1 until reset.
- Maximum throughput: one handshake per cycle. The FIFO pointers wrap modulo MaxOutstanding, and the count is kept 0..MaxOutstanding.

Test Plan:
- Single instruction fetch: imem_req_i=1, addr 0x100, mem_gnt_i=1 -> same-cycle imem_gnt_o=1 with mem_addr_o=0x100, be=0xF, we=0. Next-cycle rvalid with rdata 0xDEADBEEF -> imem_rvalid_o=1, imem_rdata_o=0xDEADBEEF, dmem_rvalid_o=0.
- Simultaneous requests from reset (imem 0x200, dmem store 0x1000) for 2 cycles with gnt=1 -> data granted in cycle 0, instruction in cycle 1. Responses return in that order to dmem then imem.
- Lock: dmem requests with mem_gnt_i=0 for 3 cycles while imem also requests -> mem_addr_o stays at the dmem address and imem_gnt_o=0 throughout. Grant on cycle 4 -> dmem_gnt_o=1, imem is selected the following cycle.
- Full FIFO: MaxOutstanding=2, two granted reads without responses -> a third request sees mem_req_o=0. A response arrives in the same cycle -> still 0. Next cycle -> mem_req_o=1.
- DATA_WIDTH=64: fetch at 0x104, mem_rdata_i=0x11112222_33334444 -> imem_rdata_o=0x11112222. Fetch at 0x100 -> 0x33334444.
- Response with empty FIFO -> no port rvalid, proto_err_o=1. Assert rst_i mid-lock with 1 outstanding -> next cycle mem_req_o follows fresh arbitration, FIFO empty, proto_err_o=0.
